// File: rtl/shot_dispatcher.sv
// shot_dispatcher: turns the fire key into one-hot deploy pulses with slot tracking, cooldown and auto-fire
module shot_dispatcher #(
    parameter int NUM_OF_SHOTS    = 8,
    parameter int COOLDOWN_FRAMES = 4,
    parameter int AUTOFIRE_FRAMES = 12,
    parameter int Y_TOP_LIMIT     = -16,
    parameter int X_MAX           = 639
) (
    input  logic                                clk,
    input  logic                                resetN,
    input  logic                                startOfFrame,
    input  logic                                fire,
    input  logic [NUM_OF_SHOTS-1:0]             SingleHitPulse_shots,
    input  logic [NUM_OF_SHOTS-1:0][1:0][10:0]  shotsCoordinates,
    output logic [NUM_OF_SHOTS-1:0]             deploy_shot,
    output logic [NUM_OF_SHOTS-1:0]             shots_busy,
    output logic [3:0]                          shots_in_flight,
    output logic                                fire_ready
);
    typedef enum logic [1:0] {IDLE, ARMED, DEPLOY, COOLDOWN} state_t;

    localparam logic signed [10:0] Y_LIM   = 11'(Y_TOP_LIMIT);
    localparam logic signed [10:0] X_HI    = 11'(X_MAX);
    localparam logic signed [10:0] X_LO    = -11'sd16;
    localparam logic [7:0]         CD_LOAD = 8'(COOLDOWN_FRAMES);
    localparam logic [7:0]         AF_LOAD = 8'(AUTOFIRE_FRAMES);
    localparam logic               AF_EN   = (AUTOFIRE_FRAMES != 0);

    state_t                  state_q;
    logic [NUM_OF_SHOTS-1:0] busy_q, busy_d, grace_q, grace_d, deploy_q, free, pick;
    logic [7:0]              cool_q, af_q;
    logic                    fire_d_q, pend_q, fire_rise, go, auto_arm;

    // slot selection, deploy decision and slot release by collision / position
    always_comb begin
        free      = ~busy_q;
        pick      = free & (~free + NUM_OF_SHOTS'(1));
        fire_rise = fire & ~fire_d_q;
        go        = (state_q == ARMED) && startOfFrame && fire && (|free);
        // arm one frame before the counter expires so the ARMED-sampled frame is the expiry frame
        auto_arm  = AF_EN && fire && (cool_q == 8'd0) && (af_q <= 8'd1);
        busy_d    = busy_q & ~SingleHitPulse_shots;
        grace_d   = grace_q;
        for (int i = 0; i < NUM_OF_SHOTS; i++) begin
            if (startOfFrame && busy_q[i]) begin
                if (grace_q[i])
                    grace_d[i] = 1'b0;
                else if ($signed(shotsCoordinates[i][1]) <= Y_LIM ||
                         $signed(shotsCoordinates[i][0]) > X_HI ||
                         $signed(shotsCoordinates[i][0]) < X_LO)
                    busy_d[i] = 1'b0;
            end
        end
        busy_d  = go ? (busy_d | pick) : busy_d;
        grace_d = go ? (grace_d | pick) : grace_d;
    end

    // launch FSM with frame counters, occupancy and registered deploy pulse
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q  <= IDLE;
            busy_q   <= '0;
            grace_q  <= '0;
            deploy_q <= '0;
            cool_q   <= 8'd0;
            af_q     <= 8'd0;
            fire_d_q <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            fire_d_q <= fire;
            busy_q   <= busy_d;
            grace_q  <= grace_d;
            deploy_q <= go ? pick : '0;
            if (go) begin
                cool_q <= CD_LOAD;
                af_q   <= AF_LOAD;
            end else begin
                if (startOfFrame && cool_q != 8'd0) cool_q <= cool_q - 8'd1;
                if (startOfFrame && af_q != 8'd0) af_q <= af_q - 8'd1;
            end
            case (state_q)
                IDLE: if (fire_rise || auto_arm) state_q <= ARMED;
                ARMED: if (startOfFrame) state_q <= !fire ? IDLE : (|free) ? DEPLOY : ARMED;
                DEPLOY: begin
                    state_q <= COOLDOWN;
                    pend_q  <= fire_rise;
                end
                COOLDOWN: begin
                    if (fire_rise) pend_q <= 1'b1;
                    if (cool_q == 8'd0) begin
                        state_q <= (pend_q || fire_rise || auto_arm) ? ARMED : IDLE;
                        pend_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign deploy_shot     = deploy_q;
    assign shots_busy      = busy_q;
    assign shots_in_flight = 4'($countones(busy_q));
    assign fire_ready      = (cool_q == 8'd0) && (|free);
endmodule

// File: tb/tb_shot_dispatcher.sv
// tb_shot_dispatcher: directed vectors with hand-computed expectations for shot_dispatcher
module tb_shot_dispatcher;
    logic                  clk, resetN, startOfFrame, fire;
    logic [7:0]            hit;
    logic [7:0][1:0][10:0] coords;
    logic [7:0]            deploy_shot, shots_busy;
    logic [3:0]            shots_in_flight;
    logic                  fire_ready;
    int                    n_checks, n_errors, n;

    shot_dispatcher dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .fire(fire),
        .SingleHitPulse_shots(hit), .shotsCoordinates(coords),
        .deploy_shot(deploy_shot), .shots_busy(shots_busy),
        .shots_in_flight(shots_in_flight), .fire_ready(fire_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic sof);
        startOfFrame = sof;
        @(posedge clk);
        #1;
        startOfFrame = 1'b0;
    endtask

    task automatic frame();
        step(1'b1);
        repeat (3) step(1'b0);
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        resetN = 1'b0; startOfFrame = 1'b0; fire = 1'b0; hit = '0;
        for (int i = 0; i < 8; i++) begin
            coords[i][0] = 11'd100;
            coords[i][1] = 11'd100;
        end
        repeat (3) step(1'b0);
        check("rst_deploy", deploy_shot, 8'h00);
        check("rst_busy", shots_busy, 8'h00);
        check("rst_inflight", shots_in_flight, 4'd0);
        check("rst_ready", fire_ready, 1'b1);
        resetN = 1'b1;
        // first shot: rise at cycle 10, frame pulse at cycle 20
        repeat (10) step(1'b0);
        fire = 1'b1;
        repeat (9) step(1'b0);
        check("pre_sof_deploy", deploy_shot, 8'h00);
        step(1'b1);
        check("first_deploy", deploy_shot, 8'h01);
        check("first_busy", shots_busy, 8'h01);
        check("first_inflight", shots_in_flight, 4'd1);
        check("first_ready", fire_ready, 1'b0);
        step(1'b0);
        check("first_pulse_end", deploy_shot, 8'h00);
        step(1'b0); step(1'b0);
        // auto-fire cadence with fire held, every 12 frames until all slots busy
        n = 1;
        for (int f = 1; f <= 110; f++) begin
            step(1'b1);
            if (deploy_shot != 8'h00) begin
                check("af_frame", f, 12 * n);
                check("af_onehot", deploy_shot, 32'd1 << n);
                n++;
            end
            if (f == 3) check("cool_ready_f3", fire_ready, 1'b0);
            if (f == 4) check("cool_ready_f4", fire_ready, 1'b1);
            step(1'b0);
            check("af_pulse_width", deploy_shot, 8'h00);
            step(1'b0); step(1'b0);
        end
        check("af_count", n, 8);
        check("full_busy", shots_busy, 8'hFF);
        check("full_inflight", shots_in_flight, 4'd8);
        check("full_ready", fire_ready, 1'b0);
        // collision frees slot 4, next deploy reuses it
        fire = 1'b0;
        hit = 8'h10;
        step(1'b0);
        hit = 8'h00;
        check("hit_busy", shots_busy, 8'hEF);
        check("hit_inflight", shots_in_flight, 4'd7);
        check("hit_ready", fire_ready, 1'b1);
        step(1'b1);
        check("armed_release", deploy_shot, 8'h00);
        step(1'b0);
        fire = 1'b1;
        step(1'b0);
        step(1'b1);
        check("reuse_deploy", deploy_shot, 8'h10);
        check("reuse_busy", shots_busy, 8'hFF);
        // reset during the deploy cycle
        fire = 1'b0;
        hit = 8'h01;
        step(1'b0);
        hit = 8'h00;
        repeat (6) frame();
        fire = 1'b1;
        step(1'b0);
        step(1'b1);
        check("pre_rst_deploy", deploy_shot, 8'h01);
        resetN = 1'b0;
        #1;
        check("async_deploy", deploy_shot, 8'h00);
        check("async_busy", shots_busy, 8'h00);
        check("async_inflight", shots_in_flight, 4'd0);
        check("async_ready", fire_ready, 1'b1);
        fire = 1'b0;
        step(1'b0);
        resetN = 1'b1;
        step(1'b1);
        check("post_rst_idle", deploy_shot, 8'h00);
        step(1'b0);
        // grace frame: off-screen Y ignored for one frame after deploy
        coords[0][1] = 11'h7EC;
        fire = 1'b1;
        step(1'b0);
        step(1'b1);
        check("grace_deploy", deploy_shot, 8'h01);
        repeat (3) step(1'b0);
        step(1'b1);
        check("grace_hold", shots_busy, 8'h01);
        repeat (3) step(1'b0);
        step(1'b1);
        check("grace_clear", shots_busy, 8'h00);
        fire = 1'b0;
        coords[0][1] = 11'd100;
        repeat (6) frame();
        // rise captured during cooldown, deploy after cooldown expires
        fire = 1'b1;
        step(1'b0);
        step(1'b1);
        check("pend_first", deploy_shot, 8'h01);
        fire = 1'b0;
        repeat (3) step(1'b0);
        frame();
        step(1'b1);
        step(1'b0);
        fire = 1'b1;
        step(1'b0);
        step(1'b0);
        step(1'b1);
        check("pend_sof3", deploy_shot, 8'h00);
        step(1'b0);
        step(1'b1);
        check("pend_sof4", deploy_shot, 8'h00);
        step(1'b0);
        check("pend_gap", deploy_shot, 8'h00);
        step(1'b1);
        check("pend_deploy", deploy_shot, 8'h02);
        check("pend_busy", shots_busy, 8'h03);
        fire = 1'b0;
        hit = 8'h80;
        step(1'b0);
        hit = 8'h00;
        check("idle_hit_ignored", shots_busy, 8'h03);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/shot_dispatcher.md
Name: shot_dispatcher

Overview:
- Launch-side controller for the shot subsystem. It turns the player fire key into one-hot, single-cycle deploy pulses on the shot-top `deploy_shot` bus.
- Tracks slot occupancy: slots are released by per-shot collision pulses or by a shot leaving the screen.
- Enforces a frame-based cooldown and auto-fire cadence.
- Sits between the keypad decoder and the shot top; it consumes `shotsCoordinates` and `SingleHitPulse_shots` from the shot top and the collision logic.

Parameters:
- NUM_OF_SHOTS, 8: number of shot slots; must match the shot top.
- COOLDOWN_FRAMES, 4: minimum frames between deploys; range 1..255.
- AUTOFIRE_FRAMES, 12: frames between repeat deploys while fire is held; 0 disables auto-fire; must be >= COOLDOWN_FRAMES.
- Y_TOP_LIMIT, -16: signed Y at or below which a shot is off-screen.
- X_MAX, 639: signed X above which a shot is off-screen; X < -16 is also off-screen.

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-cycle pulse per video frame
- fire  in  1  level fire key, already synchronised
- SingleHitPulse_shots  in  NUM_OF_SHOTS  per-slot collision pulse
- shotsCoordinates  in  NUM_OF_SHOTS x 2 x 11  per-slot signed {Y,X} top-left; index 0 = X, 1 = Y
- deploy_shot  out  NUM_OF_SHOTS  one-hot, one-cycle deploy pulse
- shots_busy  out  NUM_OF_SHOTS  slot occupancy vector
- shots_in_flight  out  4  popcount of shots_busy
- fire_ready  out  1  high when cooldown is 0 and at least one slot is free

Behaviour:
- Reset: clk and resetN are the only clock/reset; resetN is asynchronous active-low.
  - Reset values: state = IDLE; busy = 0; cooldown = 0; autofire counter = 0; fire_d = 0; grace = 0.
  - Output reset values: deploy_shot = 0, shots_busy = 0, shots_in_flight = 0, fire_ready = 1.
  - Assertion mid-pulse clears deploy_shot immediately.
- Edge detect: fire_rise = fire & ~fire_d; fire_d is registered every clk.
- FSM states: IDLE, ARMED, DEPLOY, COOLDOWN.
  - IDLE -> ARMED on fire_rise.
  - ARMED -> DEPLOY at startOfFrame if any slot is free. If none are free, stay ARMED; the request is kept until fire is released. ARMED with fire low at startOfFrame -> IDLE.
  - DEPLOY lasts exactly 1 clk. deploy_shot = one-hot of the lowest-index free slot, selected at ARMED exit. That slot's busy bit and grace bit are set in the same cycle. cooldown is loaded with COOLDOWN_FRAMES and the autofire counter with AUTOFIRE_FRAMES. Next state is COOLDOWN.
  - COOLDOWN: cooldown and autofire counter each decrement on startOfFrame, saturating at 0.
  - COOLDOWN exits when cooldown reaches 0: -> IDLE if fire is low; -> ARMED if fire_rise was captured during cooldown (latched flag).
  - Auto-fire: if fire is held, AUTOFIRE_FRAMES != 0, and the autofire counter reaches 0 in IDLE or COOLDOWN with cooldown 0 -> ARMED.
- Deploy latency: deploy_shot is asserted in the clk after the startOfFrame that was sampled in ARMED. It never goes high outside that cycle.
- Release by collision: SingleHitPulse_shots[i] clears busy[i] on the next clk edge. A pulse on a non-busy slot is ignored.
- Release by position: at startOfFrame, each busy slot is checked.
  - Grace frame: if grace[i] is set, clear grace[i] and skip the check. Coordinates are stale for one frame after deploy.
  - Otherwise busy[i] is cleared if Y <= Y_TOP_LIMIT, X > X_MAX, or X < -16. All comparisons are signed 11-bit.
- Simultaneous events:
  - Release and deploy in the same cycle: the released slot is not eligible until the next cycle; selection uses registered busy.
  - Multiple releases in one cycle are all honoured.
- shots_in_flight and fire_ready are combinational from registered state.

Test Plan:
- Reset, then fire rises at cycle 10; startOfFrame at cycle 20 -> deploy_shot = 8'h01 for exactly cycle 21; shots_busy = 8'h01; shots_in_flight = 1; fire_ready = 0 for 4 frames.
- Fire held, AUTOFIRE_FRAMES = 12, coordinates kept on-screen -> deploys on frames 0, 12, 24, ... with one-hot values 01, 02, 04, ...; after 8 deploys no further pulses; fire_ready = 0.
- 8 slots busy, SingleHitPulse_shots = 8'h10 for 1 clk, fire_rise -> next deploy_shot = 8'h10; other bits untouched.
- Slot 0 deployed with Y = -20 presented immediately -> busy[0] stays 1 through the grace frame and clears at the second startOfFrame.
- fire_rise during COOLDOWN at frame 2 -> deploy occurs at the startOfFrame after cooldown reaches 0, not earlier.
- resetN low during the DEPLOY cycle -> deploy_shot = 0 asynchronously; all busy bits 0; state IDLE after release.
